// File: rtl/timer_pkg.sv
// Shared types and constants for the interval timer: FSM states, register
// addresses and CONTROL bit positions.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    COUNT = 2'd2
  } tmr_state_t;

  localparam logic [1:0] ADDR_RELOAD   = 2'd0;
  localparam logic [1:0] ADDR_CONTROL  = 2'd1;
  localparam logic [1:0] ADDR_PRESCALE = 2'd2;

  localparam int CTRL_RUN        = 0;
  localparam int CTRL_ONESHOT    = 1;
  localparam int CTRL_SRC        = 2;
  localparam int CTRL_IRQ_EN     = 3;
  localparam int CTRL_FORCE_LOAD = 4;

endpackage

// File: rtl/interval_timer_ctrl_if.sv
// Host register bus, external event input and timer status outputs.
// The host drives through 'master'; the timer attaches through 'slave'.
interface interval_timer_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             reg_wr;
  logic [1:0]       reg_addr;
  logic [7:0]       reg_din;
  logic             ext_tick;
  logic             irq_ack;
  logic [WIDTH-1:0] count;
  logic             tc_pulse;
  logic             irq;
  logic             running;

  modport master (
    output reg_wr, reg_addr, reg_din, ext_tick, irq_ack,
    input  count, tc_pulse, irq, running
  );

  modport slave (
    input  reg_wr, reg_addr, reg_din, ext_tick, irq_ack,
    output count, tc_pulse, irq, running
  );
endinterface

// File: rtl/timer_tick_gen.sv
// Count-enable tick source: a reloadable prescaler or a synchronised,
// edge-detected external event, selected by src_i.
module timer_tick_gen
  import timer_pkg::*;
#(
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  src_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  input  logic                  clear_i,
  input  logic                  ext_tick_i,
  output logic                  tick_o
);

  logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [PRESCALE_W-1:0] pre_act_q, pre_act_d;
  logic [2:0]            ext_sync_q;
  logic                  pre_tick;
  logic                  ext_edge;

  // The prescale value in use is only refreshed at a wrap, so a host write
  // never truncates or stretches the period already in progress.
  assign pre_tick = (pre_cnt_q == pre_act_q);
  assign ext_edge = ext_sync_q[1] & ~ext_sync_q[2];
  assign tick_o   = src_i ? ext_edge : pre_tick;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    pre_cnt_d = pre_cnt_q + PRESCALE_W'(1);
    pre_act_d = pre_act_q;
    if (clear_i || src_i || pre_tick) begin
      pre_cnt_d = '0;
      pre_act_d = prescale_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt_q  <= '0;
      pre_act_q  <= '0;
      ext_sync_q <= '0;
    end else begin
      pre_cnt_q  <= pre_cnt_d;
      pre_act_q  <= pre_act_d;
      ext_sync_q <= {ext_sync_q[1:0], ext_tick_i};
    end
  end

endmodule

// File: rtl/interval_timer_ctrl.sv
// Programmable interval timer: host registers, load/count FSM, loadable
// up-counter with reload on terminal count, and a latched interrupt.
module interval_timer_ctrl
  import timer_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  interval_timer_ctrl_if.slave bus
);

  localparam logic [WIDTH-1:0] COUNT_MAX = '1;

  tmr_state_t            state_q, state_d;
  logic [WIDTH-1:0]      count_q, count_d;
  logic [WIDTH-1:0]      reload_q, reload_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic                  run_q, run_d;
  logic                  oneshot_q, oneshot_d;
  logic                  src_q, src_d;
  logic                  irq_en_q, irq_en_d;
  logic                  tc_q, tc_d;
  logic                  irq_q, irq_d;
  logic                  running_q, running_d;
  logic                  irq_set;
  logic                  tick;
  logic                  ctrl_wr;
  logic                  force_ld;

  timer_tick_gen #(.PRESCALE_W(PRESCALE_W)) u_tick_gen (
    .clk       (clk),
    .rst       (rst),
    .src_i     (src_q),
    .prescale_i(prescale_q),
    .clear_i   (state_q == LOAD),
    .ext_tick_i(bus.ext_tick),
    .tick_o    (tick)
  );

  assign ctrl_wr  = bus.reg_wr && (bus.reg_addr == ADDR_CONTROL);
  assign force_ld = ctrl_wr && bus.reg_din[CTRL_FORCE_LOAD];

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    reload_d   = reload_q;
    prescale_d = prescale_q;
    run_d      = run_q;
    oneshot_d  = oneshot_q;
    src_d      = src_q;
    irq_en_d   = irq_en_q;
    tc_d       = 1'b0;
    irq_set    = 1'b0;

    if (bus.reg_wr) begin
      case (bus.reg_addr)
        ADDR_RELOAD:   reload_d = bus.reg_din[WIDTH-1:0];
        ADDR_CONTROL: begin
          run_d     = bus.reg_din[CTRL_RUN];
          oneshot_d = bus.reg_din[CTRL_ONESHOT];
          src_d     = bus.reg_din[CTRL_SRC];
          irq_en_d  = bus.reg_din[CTRL_IRQ_EN];
        end
        ADDR_PRESCALE: prescale_d = bus.reg_din[PRESCALE_W-1:0];
        default: ;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (ctrl_wr && (bus.reg_din[CTRL_RUN] || force_ld)) state_d = LOAD;
      end
      LOAD: begin
        count_d = reload_q;
        if (force_ld)   state_d = LOAD;
        else if (run_d) state_d = COUNT;
        else            state_d = IDLE;
      end
      COUNT: begin
        // Host stop/reload requests pre-empt any tick arriving in the same cycle.
        if (force_ld) begin
          state_d = LOAD;
        end else if (ctrl_wr && !bus.reg_din[CTRL_RUN]) begin
          state_d = IDLE;
        end else if (tick) begin
          if (count_q != COUNT_MAX) begin
            count_d = count_q + WIDTH'(1);
          end else begin
            count_d = reload_q;
            tc_d    = 1'b1;
            irq_set = irq_en_q;
            if (oneshot_d) begin
              run_d   = 1'b0;
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    irq_d = irq_q;
    if (bus.irq_ack) irq_d = 1'b0;
    if (irq_set)     irq_d = 1'b1;

    running_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      reload_q   <= '0;
      prescale_q <= '0;
      run_q      <= 1'b0;
      oneshot_q  <= 1'b0;
      src_q      <= 1'b0;
      irq_en_q   <= 1'b0;
      tc_q       <= 1'b0;
      irq_q      <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      reload_q   <= reload_d;
      prescale_q <= prescale_d;
      run_q      <= run_d;
      oneshot_q  <= oneshot_d;
      src_q      <= src_d;
      irq_en_q   <= irq_en_d;
      tc_q       <= tc_d;
      irq_q      <= irq_d;
      running_q  <= running_d;
    end
  end

  assign bus.count    = count_q;
  assign bus.tc_pulse = tc_q;
  assign bus.irq      = irq_q;
  assign bus.running  = running_q;

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Self-checking bench for interval_timer_ctrl: a vector table for free-running
// counting and IRQ acknowledge, plus directed sequences for the corner cases.
module tb_interval_timer_ctrl;
  import timer_pkg::*;

  typedef struct packed {
    logic [7:0] count;
    logic       tc;
    logic       irq;
    logic       run;
  } exp_t;

  typedef struct packed {
    logic       wr;
    logic [1:0] addr;
    logic [7:0] din;
    logic       ack;
    exp_t       exp;
  } vec_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  exp_t  sb_q[$];
  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  string phase = "reset";

  interval_timer_ctrl_if #(.WIDTH(8)) bus ();

  interval_timer_ctrl #(.WIDTH(8), .PRESCALE_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [7:0] c, input logic t, input logic i, input logic r);
    exp_t e;
    e.count = c;
    e.tc    = t;
    e.irq   = i;
    e.run   = r;
    return e;
  endfunction

  function automatic vec_t v(input logic w, input logic [1:0] a, input logic [7:0] d,
                             input logic k, input exp_t e);
    vec_t r;
    r.wr   = w;
    r.addr = a;
    r.din  = d;
    r.ack  = k;
    r.exp  = e;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s.%s cyc=%0d: got %0h expected %0h", phase, name, cyc, act, req);
    end
  endtask

  task automatic check_outputs(input exp_t e);
    check("count",    bus.count,    e.count);
    check("tc_pulse", bus.tc_pulse, e.tc);
    check("irq",      bus.irq,      e.irq);
    check("running",  bus.running,  e.run);
  endtask

  // Drive one cycle of inputs, queue its expected outcome, and compare once
  // the DUT has taken the clock edge.
  task automatic cycle(input logic wr, input logic [1:0] addr, input logic [7:0] din,
                       input logic ack, input logic ext, input exp_t e);
    exp_t exp_now;
    bus.reg_wr   = wr;
    bus.reg_addr = addr;
    bus.reg_din  = din;
    bus.irq_ack  = ack;
    bus.ext_tick = ext;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    exp_now = sb_q.pop_front();
    check_outputs(exp_now);
  endtask

  task automatic wr(input logic [1:0] addr, input logic [7:0] din, input exp_t e);
    cycle(1'b1, addr, din, 1'b0, 1'b0, e);
  endtask

  task automatic idle(input exp_t e);
    cycle(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, e);
  endtask

  task automatic quiet_inputs();
    bus.reg_wr   = 1'b0;
    bus.reg_addr = 2'd0;
    bus.reg_din  = 8'h00;
    bus.irq_ack  = 1'b0;
    bus.ext_tick = 1'b0;
  endtask

  task automatic do_reset();
    quiet_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  vec_t t1[13];

  initial begin
    quiet_inputs();
    do_reset();
    check_outputs(mk(8'h00, 1'b0, 1'b0, 1'b0));

    // Free-running FD..FF wrap with IRQ, then ack colliding with a new TC.
    phase = "t1";
    t1[0]  = v(1'b1, ADDR_RELOAD,   8'hFD, 1'b0, mk(8'h00, 0, 0, 0));
    t1[1]  = v(1'b1, ADDR_PRESCALE, 8'h00, 1'b0, mk(8'h00, 0, 0, 0));
    t1[2]  = v(1'b1, ADDR_CONTROL,  8'h09, 1'b0, mk(8'h00, 0, 0, 1));
    t1[3]  = v(1'b0, 2'd0,          8'h00, 1'b0, mk(8'hFD, 0, 0, 1));
    t1[4]  = v(1'b0, 2'd0,          8'h00, 1'b0, mk(8'hFE, 0, 0, 1));
    t1[5]  = v(1'b0, 2'd0,          8'h00, 1'b0, mk(8'hFF, 0, 0, 1));
    t1[6]  = v(1'b0, 2'd0,          8'h00, 1'b0, mk(8'hFD, 1, 1, 1));
    t1[7]  = v(1'b0, 2'd0,          8'h00, 1'b0, mk(8'hFE, 0, 1, 1));
    t1[8]  = v(1'b0, 2'd0,          8'h00, 1'b0, mk(8'hFF, 0, 1, 1));
    t1[9]  = v(1'b0, 2'd0,          8'h00, 1'b1, mk(8'hFD, 1, 1, 1));
    t1[10] = v(1'b0, 2'd0,          8'h00, 1'b1, mk(8'hFE, 0, 0, 1));
    t1[11] = v(1'b0, 2'd0,          8'h00, 1'b0, mk(8'hFF, 0, 0, 1));
    t1[12] = v(1'b0, 2'd0,          8'h00, 1'b0, mk(8'hFD, 1, 1, 1));
    for (int i = 0; i < 13; i++)
      cycle(t1[i].wr, t1[i].addr, t1[i].din, t1[i].ack, 1'b0, t1[i].exp);

    // One-shot with PRESCALE=3: four clocks per step, stops after FF.
    do_reset();
    phase = "t2";
    wr(ADDR_RELOAD,   8'hFE, mk(8'h00, 0, 0, 0));
    wr(ADDR_PRESCALE, 8'h03, mk(8'h00, 0, 0, 0));
    wr(ADDR_CONTROL,  8'h0B, mk(8'h00, 0, 0, 1));
    for (int k = 1; k <= 9; k++)
      idle(mk((k <= 4) ? 8'hFE : (k <= 8) ? 8'hFF : 8'hFE, k == 9, k == 9, k != 9));
    for (int k = 0; k < 50; k++)
      idle(mk(8'hFE, 0, 1, 0));

    // External ticks: each rising edge lands on COUNT_Q three clocks later.
    do_reset();
    phase = "t4";
    wr(ADDR_RELOAD,   8'h10, mk(8'h00, 0, 0, 0));
    wr(ADDR_PRESCALE, 8'h00, mk(8'h00, 0, 0, 0));
    wr(ADDR_CONTROL,  8'h05, mk(8'h00, 0, 0, 1));
    idle(mk(8'h10, 0, 0, 1));
    for (int p = 0; p < 5; p++)
      for (int j = 0; j < 8; j++)
        cycle(1'b0, 2'd0, 8'h00, 1'b0, j < 4, mk(8'h10 + 8'(p) + 8'(j >= 2), 0, 0, 1));
    check("final", bus.count, 8'h15);

    // RELOAD write mid-count is deferred; FORCE_LOAD applies it; RUN=0 stops.
    do_reset();
    phase = "t5";
    wr(ADDR_RELOAD,  8'h40, mk(8'h00, 0, 0, 0));
    wr(ADDR_CONTROL, 8'h05, mk(8'h00, 0, 0, 1));
    for (int k = 0; k < 3; k++) idle(mk(8'h40, 0, 0, 1));
    wr(ADDR_RELOAD,  8'h80, mk(8'h40, 0, 0, 1));
    for (int k = 0; k < 3; k++) idle(mk(8'h40, 0, 0, 1));
    wr(ADDR_CONTROL, 8'h15, mk(8'h40, 0, 0, 1));
    idle(mk(8'h80, 0, 0, 1));
    wr(ADDR_CONTROL, 8'h00, mk(8'h80, 0, 0, 0));
    for (int k = 0; k < 5; k++) idle(mk(8'h80, 0, 0, 0));

    // Asynchronous reset with IRQ pending, then restart only on a RUN write.
    do_reset();
    phase = "t6";
    wr(ADDR_RELOAD,  8'hFD, mk(8'h00, 0, 0, 0));
    wr(ADDR_CONTROL, 8'h09, mk(8'h00, 0, 0, 1));
    idle(mk(8'hFD, 0, 0, 1));
    idle(mk(8'hFE, 0, 0, 1));
    idle(mk(8'hFF, 0, 0, 1));
    idle(mk(8'hFD, 1, 1, 1));
    idle(mk(8'hFE, 0, 1, 1));
    #2;
    rst = 1'b1;
    #1;
    check_outputs(mk(8'h00, 0, 0, 0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) idle(mk(8'h00, 0, 0, 0));
    wr(ADDR_CONTROL, 8'h01, mk(8'h00, 0, 0, 1));
    idle(mk(8'h00, 0, 0, 1));
    idle(mk(8'h01, 0, 0, 1));
    idle(mk(8'h02, 0, 0, 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
